// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the Maxnet winner-take-all engine.
// Configuration macro: MAXNET_ITER_LIMIT_EN enables the iteration cap and timeout port.
package maxnet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ITER,
    DONE
  } state_e;

  localparam int unsigned CNT_MAX = 255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'(CNT_MAX)) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/maxnet_pe.sv
// One Maxnet neuron lane: subtracts the truncated inhibition from its own activation.
// Purely combinational; the top owns all state.
module maxnet_pe
  import maxnet_pkg::*;
#(
  parameter int unsigned W      = 32,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned SUM_W  = 34,
  parameter int unsigned PROD_W = 66
) (
  input  logic [W-1:0]     a_i,
  input  logic [SUM_W-1:0] sum,
  input  logic [W-1:0]     eps,
  output logic [W-1:0]     a_next,
  output logic             nz
);

  logic [SUM_W-1:0]  others;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] inh;

  always_comb begin
    others = sum - SUM_W'(a_i);
    prod   = PROD_W'(eps) * PROD_W'(others);
    inh    = prod >> FRAC;
    a_next = (inh >= PROD_W'(a_i)) ? '0 : a_i - W'(inh);
    nz     = |a_next;
  end

endmodule

// File: rtl/maxnet_array.sv
// N-neuron Maxnet winner-take-all engine, one parallel iteration per clock, start/done handshake.
// Optional MAXNET_ITER_LIMIT_EN: stop after MAX_ITER iterations and report the largest activation.
module maxnet_array
  import maxnet_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned W        = 32,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [W-1:0]         epsilon,
  input  logic [N*W-1:0]       a_in,
  output logic                 busy,
  output logic                 done,
  output logic [W-1:0]         out,
  output logic [$clog2(N)-1:0] winner_idx,
  output logic                 no_winner,
  output logic [7:0]           iter_count
`ifdef MAXNET_ITER_LIMIT_EN
  ,
  output logic                 timeout
`endif
);

  localparam int unsigned IDX_W  = $clog2(N);
  localparam int unsigned SUM_W  = W + IDX_W;
  localparam int unsigned PROD_W = 2 * W + IDX_W;
  localparam int unsigned CNT_W  = $clog2(N + 1);

  if (N < 2 || N > 16 || MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_param
    $error("maxnet_array: parameter out of range");
  end

  state_e           state, state_n;
  logic [W-1:0]     a_reg  [N];
  logic [W-1:0]     a_next [N];
  logic [N-1:0]     pe_nz;
  logic [W-1:0]     eps_reg;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] nz_cnt;
  logic [W-1:0]     nz_val;
  logic [IDX_W-1:0] nz_idx;
  logic             in_load, accept, settled, stop_cap;

  assign in_load = (state == LOAD);
  assign accept  = start && (state == IDLE || state == DONE);
  assign busy    = (state == LOAD) || (state == ITER);

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N; i++) sum = sum + SUM_W'(a_reg[i]);
  end

  for (genvar g = 0; g < N; g++) begin : g_pe
    maxnet_pe #(.W(W), .FRAC(FRAC), .SUM_W(SUM_W), .PROD_W(PROD_W)) u_pe (
      .a_i   (a_reg[g]),
      .sum   (sum),
      .eps   (eps_reg),
      .a_next(a_next[g]),
      .nz    (pe_nz[g])
    );
  end

  // LOAD checks the freshly captured inputs; ITER checks this cycle's update.
  always_comb begin
    nz_cnt = '0;
    nz_val = '0;
    nz_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_load ? (a_reg[i] != '0) : pe_nz[i]) begin
        nz_cnt = nz_cnt + CNT_W'(1);
        nz_val = in_load ? a_reg[i] : a_next[i];
        nz_idx = IDX_W'(i);
      end
    end
    settled = (nz_cnt <= CNT_W'(1));
  end

`ifdef MAXNET_ITER_LIMIT_EN
  logic [W-1:0]     max_val;
  logic [IDX_W-1:0] max_idx;

  always_comb begin
    max_val = a_next[0];
    max_idx = '0;
    for (int unsigned i = 1; i < N; i++) begin
      if (a_next[i] > max_val) begin
        max_val = a_next[i];
        max_idx = IDX_W'(i);
      end
    end
  end

  assign stop_cap = (state == ITER) && (9'(iter_count) + 9'd1 == 9'(MAX_ITER));
`else
  assign stop_cap = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (start) state_n = LOAD;
      LOAD:       state_n = settled ? DONE : ITER;
      ITER:       if (settled || stop_cap) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) a_reg[i] <= '0;
      eps_reg    <= '0;
      done       <= 1'b0;
      out        <= '0;
      winner_idx <= '0;
      no_winner  <= 1'b0;
      iter_count <= '0;
`ifdef MAXNET_ITER_LIMIT_EN
      timeout    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < N; i++) a_reg[i] <= a_in[i*W +: W];
        eps_reg    <= epsilon;
        iter_count <= '0;
        done       <= 1'b0;
        no_winner  <= 1'b0;
`ifdef MAXNET_ITER_LIMIT_EN
        timeout    <= 1'b0;
`endif
      end else if (state == ITER) begin
        for (int unsigned i = 0; i < N; i++) a_reg[i] <= a_next[i];
        iter_count <= sat_inc8(iter_count);
      end

      if (busy && settled) begin
        done       <= 1'b1;
        out        <= nz_val;
        winner_idx <= nz_idx;
        no_winner  <= (nz_cnt == '0);
      end
`ifdef MAXNET_ITER_LIMIT_EN
      else if (stop_cap) begin
        done       <= 1'b1;
        timeout    <= 1'b1;
        out        <= max_val;
        winner_idx <= max_idx;
      end
`endif
    end
  end

endmodule
